// File: rtl/stc_psum_drain.sv
// stc_psum_drain
// Drains one accumulator result (N_PE rows of N elements) into an output
// buffer as N_PE row writes over a valid/ready handshake. The result is
// copied into a shadow register on acc_done, so the accumulator can start
// the next tile while the drain is in progress. An acc_done that arrives
// while a drain is still active is dropped and recorded in a sticky flag.

module stc_psum_drain #(
  parameter int N       = 16,  // output elements per PE row
  parameter int N_PE    = 4,   // PE rows per accumulator result
  parameter int DW_DATA = 16,  // bits per element
  parameter int ADDR_W  = 8    // output-buffer row address width
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_PE*N*DW_DATA-1:0]   acc_out,
  input  logic                        acc_done,
  input  logic [ADDR_W-1:0]           base_addr,
  output logic                        busy,
  output logic                        wr_valid,
  input  logic                        wr_ready,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [N*DW_DATA-1:0]        wr_data,
  output logic                        drain_done,
  output logic                        overrun
);

  localparam int ROW_BITS = N * DW_DATA;
  localparam int ROW_W    = (N_PE > 1) ? $clog2(N_PE) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_PE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [ROW_BITS-1:0] shadow [N_PE];
  logic [ADDR_W-1:0]   base_q;
  logic [ROW_W-1:0]    row;
  logic [ROW_W-1:0]    next_row;
  logic [ROW_BITS-1:0] next_row_data;
  logic                capture;
  logic                xfer;

  // A new result is only taken while idle; anything else is an overrun.
  assign capture       = (state == IDLE) && acc_done;
  assign xfer          = wr_valid && wr_ready;
  assign next_row      = row + 1'b1;
  assign next_row_data = shadow[next_row];

  // Shadow copy of the accumulator result and its base address.
  // NOTE: the shadow array is reset explicitly so a drain can never expose
  // stale contents from before reset; it is small enough to live in flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < N_PE; p++) begin
        shadow[p] <= '0;
      end
      base_q <= '0;
    end else if (capture) begin
      for (int p = 0; p < N_PE; p++) begin
        shadow[p] <= acc_out[p*ROW_BITS +: ROW_BITS];
      end
      base_q <= base_addr;
    end
  end

  // Drain FSM with registered handshake outputs.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      row        <= '0;
      busy       <= 1'b0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      drain_done <= 1'b0;
    end else begin
      drain_done <= 1'b0;
      case (state)
        IDLE: begin
          if (acc_done) begin
            // Row 0 comes straight from acc_out so wr_valid rises one
            // cycle after acc_done, while the shadow loads in parallel.
            state    <= SEND;
            busy     <= 1'b1;
            wr_valid <= 1'b1;
            row      <= '0;
            wr_addr  <= base_addr;
            wr_data  <= acc_out[ROW_BITS-1:0];
          end
        end
        SEND: begin
          // Without a transfer everything holds, keeping data/addr stable.
          if (xfer) begin
            if (row == LAST_ROW) begin
              state      <= DONE;
              wr_valid   <= 1'b0;
              drain_done <= 1'b1;
            end else begin
              row     <= next_row;
              wr_addr <= base_q + ADDR_W'(next_row);
              wr_data <= next_row_data;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          row   <= '0;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          wr_valid <= 1'b0;
        end
      endcase
    end
  end

  // Sticky record of any acc_done that arrived while a drain was active.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
    end else if (acc_done && (state != IDLE)) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stc_psum_drain.sv
// Testbench for stc_psum_drain: scoreboard of expected row writes filled
// when a result is captured and emptied by a write monitor, driven by a
// table of drain cases plus hand-written overrun and reset sequences.

module tb_stc_psum_drain;

  localparam int N        = 16;
  localparam int N_PE     = 4;
  localparam int DW_DATA  = 16;
  localparam int ADDR_W   = 8;
  localparam int ROW_BITS = N * DW_DATA;
  localparam int ACC_BITS = N_PE * ROW_BITS;

  typedef logic [ROW_BITS-1:0] val_t;

  logic                clk;
  logic                reset;
  logic [ACC_BITS-1:0] acc_out;
  logic                acc_done;
  logic [ADDR_W-1:0]   base_addr;
  logic                busy;
  logic                wr_valid;
  logic                wr_ready;
  logic [ADDR_W-1:0]   wr_addr;
  logic [ROW_BITS-1:0] wr_data;
  logic                drain_done;
  logic                overrun;

  stc_psum_drain #(
    .N       (N),
    .N_PE    (N_PE),
    .DW_DATA (DW_DATA),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .acc_out    (acc_out),
    .acc_done   (acc_done),
    .base_addr  (base_addr),
    .busy       (busy),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .drain_done (drain_done),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0]   addr;
    logic [ROW_BITS-1:0] data;
  } wr_t;

  typedef struct {
    logic [ADDR_W-1:0] base;
    int                mode;       // 0: wr_ready always 1, 1: alternating 0/1
    int                seed;
    int                exp_cycles; // cycles with wr_valid=1
    logic [ADDR_W-1:0] exp_last;   // address of the final write
  } case_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input val_t act, input val_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Element (p,j) of result 'seed': seed in the high byte, p*16+j in the low.
  function automatic logic [DW_DATA-1:0] elem(input int seed, input int p, input int j);
    logic [7:0] hi;
    logic [7:0] lo;
    hi = 8'(seed);
    lo = 8'(p * 16 + j);
    return {hi, lo};
  endfunction

  function automatic logic [ACC_BITS-1:0] make_acc(input int seed);
    logic [ACC_BITS-1:0] a;
    a = '0;
    for (int p = 0; p < N_PE; p++)
      for (int j = 0; j < N; j++)
        a[(p*N+j)*DW_DATA +: DW_DATA] = elem(seed, p, j);
    return a;
  endfunction

  function automatic logic [ROW_BITS-1:0] make_row(input int seed, input int p);
    logic [ROW_BITS-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++)
      r[j*DW_DATA +: DW_DATA] = elem(seed, p, j);
    return r;
  endfunction

  // Write monitor: pops the scoreboard on each transfer and checks that a
  // stalled request holds its address and data and does not drop.
  logic                prev_stall = 1'b0;
  logic [ADDR_W-1:0]   hold_addr;
  logic [ROW_BITS-1:0] hold_data;
  logic [ADDR_W-1:0]   last_addr = '0;
  wr_t                 mon_e;

  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", val_t'(wr_valid), val_t'(1));
        if (wr_valid) begin
          check("stall_addr_stable", val_t'(wr_addr), val_t'(hold_addr));
          check("stall_data_stable", wr_data, hold_data);
        end
      end
      if (wr_valid && wr_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got write to %0h, expected none", wr_addr);
        end else begin
          mon_e = sb.pop_front();
          check("wr_addr", val_t'(wr_addr), val_t'(mon_e.addr));
          check("wr_data", wr_data, mon_e.data);
        end
        last_addr = wr_addr;
      end
      prev_stall = wr_valid && !wr_ready;
      hold_addr  = wr_addr;
      hold_data  = wr_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse acc_done with result 'seed', queue its rows, then disturb the
  // inputs in the following cycle; they must not leak into the drain.
  task automatic start_capture(input logic [ADDR_W-1:0] base, input int seed);
    tick();
    acc_out   = make_acc(seed);
    base_addr = base;
    acc_done  = 1'b1;
    for (int p = 0; p < N_PE; p++) begin
      wr_t e;
      e.addr = ADDR_W'(int'(base) + p);
      e.data = make_row(seed, p);
      sb.push_back(e);
    end
    tick();
    acc_done  = 1'b0;
    acc_out   = ~make_acc(seed);
    base_addr = base ^ 8'h5A;
  endtask

  // Run the handshake until drain_done, counting cycles with wr_valid=1.
  // Starts just after a rising edge; returns at the negedge of the DONE cycle.
  task automatic drain(input int mode, input bit first, output int vcnt);
    bit saw;
    vcnt = 0;
    saw  = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      wr_ready = (mode == 0) ? 1'b1 : cyc[0];
      @(negedge clk);
      if (first && cyc == 0) check("latency_wr_valid", val_t'(wr_valid), val_t'(1));
      if (drain_done) begin
        saw = 1'b1;
        check("done_wr_valid_low", val_t'(wr_valid), val_t'(0));
        check("done_busy_high", val_t'(busy), val_t'(1));
        break;
      end
      if (wr_valid) vcnt++;
      tick();
    end
    check("drain_done_seen", val_t'(saw), val_t'(1));
  endtask

  task automatic run_case(input case_t c);
    int vcnt;
    wr_ready = 1'b0;
    start_capture(c.base, c.seed);
    drain(c.mode, 1'b1, vcnt);
    check("valid_cycles", val_t'(vcnt), val_t'(c.exp_cycles));
    check("last_addr", val_t'(last_addr), val_t'(c.exp_last));
    check("rows_all_written", val_t'(sb.size()), val_t'(0));
    tick();
    @(negedge clk);
    check("busy_low_after", val_t'(busy), val_t'(0));
    check("drain_done_pulse", val_t'(drain_done), val_t'(0));
  endtask

  case_t cases[5];
  int    vcnt_ov;

  initial begin
    cases[0] = '{base: 8'h10, mode: 0, seed: 0, exp_cycles: 4, exp_last: 8'h13};
    cases[1] = '{base: 8'h10, mode: 1, seed: 1, exp_cycles: 8, exp_last: 8'h13};
    cases[2] = '{base: 8'hFE, mode: 0, seed: 2, exp_cycles: 4, exp_last: 8'h01};
    cases[3] = '{base: 8'hFE, mode: 1, seed: 4, exp_cycles: 8, exp_last: 8'h01};
    cases[4] = '{base: 8'h00, mode: 0, seed: 7, exp_cycles: 4, exp_last: 8'h03};

    reset     = 1'b0;
    acc_out   = make_acc(8'hAA);
    acc_done  = 1'b0;
    base_addr = 8'h33;
    wr_ready  = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_busy", val_t'(busy), val_t'(0));
    check("rst_wr_valid", val_t'(wr_valid), val_t'(0));
    check("rst_drain_done", val_t'(drain_done), val_t'(0));
    check("rst_overrun", val_t'(overrun), val_t'(0));
    check("rst_wr_addr", val_t'(wr_addr), val_t'(0));
    check("rst_wr_data", wr_data, val_t'(0));
    tick();
    reset = 1'b1;

    // wr_ready while idle must not start anything
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("idle_no_valid", val_t'(wr_valid), val_t'(0));
      tick();
    end

    // Table of full drains
    for (int i = 0; i < 5; i++) run_case(cases[i]);

    // Dropped acc_done during SEND: original data drains, overrun sticks
    wr_ready = 1'b0;
    start_capture(8'h20, 3);
    @(negedge clk);
    check("ov_before", val_t'(overrun), val_t'(0));
    tick();
    acc_out  = make_acc(9);
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
    @(negedge clk);
    check("ov_set", val_t'(overrun), val_t'(1));
    tick();
    drain(0, 1'b0, vcnt_ov);
    check("ov_valid_cycles", val_t'(vcnt_ov), val_t'(4));
    check("ov_rows_written", val_t'(sb.size()), val_t'(0));
    tick();
    @(negedge clk);
    check("ov_sticky", val_t'(overrun), val_t'(1));
    check("ov_busy_low", val_t'(busy), val_t'(0));

    // Reset after the second accepted write aborts the drain
    tick();
    wr_ready = 1'b0;
    start_capture(8'h40, 5);
    wr_ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();
    reset = 1'b0;
    #1;
    check("abort_wr_valid", val_t'(wr_valid), val_t'(0));
    check("abort_busy", val_t'(busy), val_t'(0));
    check("abort_pending_rows", val_t'(sb.size()), val_t'(2));
    sb.delete();
    tick();
    @(negedge clk);
    check("abort_overrun_clr", val_t'(overrun), val_t'(0));
    check("abort_wr_addr", val_t'(wr_addr), val_t'(0));
    check("abort_wr_data", wr_data, val_t'(0));
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_idle", val_t'(wr_valid), val_t'(0));
      tick();
    end
    run_case('{base: 8'h50, mode: 0, seed: 6, exp_cycles: 4, exp_last: 8'h53});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
